// File: rtl/deal_sequencer_pkg.sv
// Shared definitions for the two-player card game controller: key codes,
// FSM state encoding, winner codes and the saturating score adder.
package game_pkg;

  localparam logic [3:0] KEY_START = 4'b1111;
  localparam logic [3:0] KEY_DRAW  = 4'b0010;
  localparam logic [3:0] KEY_END1  = 4'b0011;
  localparam logic [3:0] KEY_END2  = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_REQ,
    S_WAIT,
    S_SCORE,
    S_CHECK,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_TIE  = 2'b11
  } winner_t;

  // Scores clamp at 255 rather than wrapping back past zero.
  function automatic logic [7:0] sat_add(input logic [7:0] s, input logic [2:0] n);
    logic [8:0] t;
    t = {1'b0, s} + {6'b0, n};
    return t[8] ? 8'hFF : t[7:0];
  endfunction

endpackage

// File: rtl/deal_sequencer_if.sv
// Keypad / random source / display bundle around the deal sequencer.
interface deal_sequencer_if;
  logic       key_valid;
  logic [3:0] keypad_in;
  logic [4:0] rnd;
  logic       rng_en;
  logic       whose;
  logic       card_valid;
  logic [1:0] card_color;
  logic [2:0] card_number;
  logic [7:0] score1;
  logic [7:0] score2;
  logic [7:0] round_cnt;
  logic       finish;
  logic [1:0] winner;

  modport master (
    input  key_valid, keypad_in, rnd,
    output rng_en, whose, card_valid, card_color, card_number,
           score1, score2, round_cnt, finish, winner
  );

  modport slave (
    output key_valid, keypad_in, rnd,
    input  rng_en, whose, card_valid, card_color, card_number,
           score1, score2, round_cnt, finish, winner
  );
endinterface

// File: rtl/deal_sequencer_card_decode.sv
// Maps a 5-bit random value onto a card: colour 1..3, number 1..5.
module card_decode (
  input  logic [4:0] rnd,
  output logic [1:0] color,
  output logic [2:0] number
);
  always_comb begin
    color  = (rnd[4:3] == 2'd3) ? 2'd1 : rnd[4:3] + 2'd1;
    number = (rnd[2:0] <= 3'd4) ? rnd[2:0] + 3'd1 : rnd[2:0] - 3'd4;
  end
endmodule

// File: rtl/deal_sequencer.sv
// Game controller: arbitrates the shared RNG, sequences each draw,
// keeps turns, scores and rounds, and declares the winner.
module deal_sequencer
  import game_pkg::*;
#(
  parameter int         RNG_LAT    = 2,
  parameter int         MAX_DRAWS  = 3,
  parameter logic [7:0] TARGET     = 8'd21,
  parameter logic [7:0] MAX_ROUNDS = 8'd10
) (
  input logic              clk,
  input logic              rst,
  deal_sequencer_if.master bus
);

  state_t     state, state_n;
  logic       key_prev;
  logic       key_evt;
  logic [3:0] draw_cnt;
  logic [2:0] lat_cnt;
  logic [4:0] rnd_q;
  logic [1:0] dec_color;
  logic [2:0] dec_number;

  logic       whose;
  logic       card_valid;
  logic [1:0] card_color;
  logic [2:0] card_number;
  logic [7:0] score1, score2, round_cnt;
  logic       finish;
  winner_t    winner, win;

  logic do_start, do_end1, do_end2, cap;

  assign key_evt = bus.key_valid & ~key_prev;

  card_decode u_dec (
    .rnd   (rnd_q),
    .color (dec_color),
    .number(dec_number)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    do_start = 1'b0;
    do_end1  = 1'b0;
    do_end2  = 1'b0;
    cap      = 1'b0;
    win      = WIN_NONE;
    if (score1 >= TARGET)           win = WIN_P1;
    else if (score2 >= TARGET)      win = WIN_P2;
    else if (round_cnt == MAX_ROUNDS)
      win = (score1 > score2) ? WIN_P1 : (score2 > score1) ? WIN_P2 : WIN_TIE;
    case (state)
      S_IDLE, S_DONE: begin
        if (key_evt && bus.keypad_in == KEY_START) begin
          do_start = 1'b1;
          state_n  = S_TURN;
        end
      end
      S_TURN: begin
        if (key_evt) begin
          case (bus.keypad_in)
            KEY_DRAW: if (draw_cnt < 4'(MAX_DRAWS)) state_n = S_REQ;
            KEY_END1: if (!whose) do_end1 = 1'b1;
            KEY_END2: if (whose) begin
              do_end2 = 1'b1;
              state_n = S_CHECK;
            end
            default: ;
          endcase
        end
      end
      S_REQ:   state_n = S_WAIT;
      // lat_cnt == 1 here means it hits zero this cycle: RNG_LAT cycles after REQ.
      S_WAIT: if (lat_cnt <= 3'd1) begin
        cap     = 1'b1;
        state_n = S_SCORE;
      end
      S_SCORE: state_n = S_CHECK;
      S_CHECK: state_n = (win != WIN_NONE) ? S_DONE : S_TURN;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_prev    <= 1'b0;
      draw_cnt    <= '0;
      lat_cnt     <= '0;
      rnd_q       <= '0;
      whose       <= 1'b0;
      card_valid  <= 1'b0;
      card_color  <= '0;
      card_number <= '0;
      score1      <= '0;
      score2      <= '0;
      round_cnt   <= '0;
      finish      <= 1'b0;
      winner      <= WIN_NONE;
    end else begin
      key_prev   <= bus.key_valid;
      card_valid <= 1'b0;
      if (do_start) begin
        score1    <= '0;
        score2    <= '0;
        round_cnt <= '0;
        winner    <= WIN_NONE;
        finish    <= 1'b0;
        draw_cnt  <= '0;
        whose     <= 1'b0;
      end
      if (do_end1) begin
        whose    <= 1'b1;
        draw_cnt <= '0;
      end
      if (do_end2) begin
        whose     <= 1'b0;
        draw_cnt  <= '0;
        round_cnt <= round_cnt + 8'd1;
      end
      if (state == S_REQ)  lat_cnt <= 3'(RNG_LAT);
      if (state == S_WAIT) lat_cnt <= lat_cnt - 3'd1;
      if (cap)             rnd_q   <= bus.rnd;
      if (state == S_SCORE) begin
        card_color  <= dec_color;
        card_number <= dec_number;
        card_valid  <= 1'b1;
        draw_cnt    <= draw_cnt + 4'd1;
        if (whose) score2 <= sat_add(score2, dec_number);
        else       score1 <= sat_add(score1, dec_number);
      end
      if (state == S_CHECK && win != WIN_NONE) begin
        winner <= win;
        finish <= 1'b1;
      end
    end
  end

  assign bus.rng_en      = (state == S_REQ);
  assign bus.whose       = whose;
  assign bus.card_valid  = card_valid;
  assign bus.card_color  = card_color;
  assign bus.card_number = card_number;
  assign bus.score1      = score1;
  assign bus.score2      = score2;
  assign bus.round_cnt   = round_cnt;
  assign bus.finish      = finish;
  assign bus.winner      = winner;

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench: stimulus pushes expected cards, a monitor checks each card_valid.
module tb_deal_sequencer;
  import game_pkg::*;

  localparam int RNG_LAT = 2;

  typedef struct {
    logic [1:0] c;
    logic [2:0] n;
    logic [7:0] s1;
    logic [7:0] s2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  deal_sequencer_if bus ();

  deal_sequencer #(
    .RNG_LAT   (RNG_LAT),
    .MAX_DRAWS (3),
    .TARGET    (8'd8),
    .MAX_ROUNDS(8'd1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Random source model: the programmed value appears only RNG_LAT cycles after rng_en.
  logic [RNG_LAT-1:0] rpipe = '0;
  logic [4:0]         next_rnd = 5'h1F;
  always @(posedge clk) rpipe <= (rpipe << 1) | RNG_LAT'(bus.rng_en);
  assign bus.rnd = rpipe[RNG_LAT-1] ? next_rnd : 5'h1F;

  exp_t q[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   rng_seen = 0;
  int   exp_rng  = 0;
  logic rng_prev = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rng_en) begin
        rng_seen++;
        if (rng_prev) chk("rng_en_b2b", 1, 0);
      end
      rng_prev <= bus.rng_en;
      if (bus.card_valid) begin
        if (q.size() == 0) chk("card_unexpected", int'(bus.card_valid), 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("card_color",  int'(bus.card_color),  int'(e.c));
          chk("card_number", int'(bus.card_number), int'(e.n));
          chk("card_score1", int'(bus.score1),      int'(e.s1));
          chk("card_score2", int'(bus.score2),      int'(e.s2));
        end
      end
    end else rng_prev <= 1'b0;
  end

  task automatic press(input logic [3:0] code, input int hold);
    @(posedge clk); #1;
    bus.key_valid = 1'b1;
    bus.keypad_in = code;
    repeat (hold) @(posedge clk);
    #1 bus.key_valid = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic draw(input logic [4:0] r, input logic [1:0] c, input logic [2:0] n,
                      input logic [7:0] s1, input logic [7:0] s2);
    exp_t e;
    e = '{c: c, n: n, s1: s1, s2: s2};
    next_rnd = r;
    q.push_back(e);
    exp_rng++;
    press(KEY_DRAW, 1);
  endtask

  task automatic chk_state(input string tag, input int w, input int s1, input int s2,
                           input int rc, input int fin, input int win);
    @(negedge clk);
    chk({tag, "_whose"},  int'(bus.whose),     w);
    chk({tag, "_score1"}, int'(bus.score1),    s1);
    chk({tag, "_score2"}, int'(bus.score2),    s2);
    chk({tag, "_round"},  int'(bus.round_cnt), rc);
    chk({tag, "_finish"}, int'(bus.finish),    fin);
    chk({tag, "_winner"}, int'(bus.winner),    win);
    chk({tag, "_rng"},    rng_seen,            exp_rng);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rng_en"},  int'(bus.rng_en),      0);
    chk({tag, "_cvalid"},  int'(bus.card_valid),  0);
    chk({tag, "_ccolor"},  int'(bus.card_color),  0);
    chk({tag, "_cnumber"}, int'(bus.card_number), 0);
    chk_state(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.keypad_in = 4'h0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    press(KEY_START, 1);
    chk_state("start", 0, 0, 0, 0, 0, 0);

    // Decode and latency, then the draw cap within player 1's turn.
    draw(5'b01011, 2'd2, 3'd4, 8'd4, 8'd0);
    draw(5'b11110, 2'd1, 3'd2, 8'd6, 8'd0);
    draw(5'b00000, 2'd1, 3'd1, 8'd7, 8'd0);
    press(KEY_DRAW, 1);
    chk_state("cap", 0, 7, 0, 0, 0, 0);

    press(KEY_END2, 1);
    chk_state("end2_wrong", 0, 7, 0, 0, 0, 0);
    press(KEY_END1, 1);
    chk_state("end1", 1, 7, 0, 0, 0, 0);

    // Held key: a single draw for player 2.
    begin
      exp_t e;
      e = '{c: 2'd2, n: 3'd1, s1: 8'd7, s2: 8'd1};
      next_rnd = 5'b01000;
      q.push_back(e);
      exp_rng++;
      press(KEY_DRAW, 10);
    end
    chk_state("held", 1, 7, 1, 0, 0, 0);

    // Round limit of 1 ends the game on score.
    press(KEY_END2, 1);
    chk_state("rounds", 0, 7, 1, 1, 1, 1);
    press(KEY_DRAW, 1);
    chk_state("done_draw", 0, 7, 1, 1, 1, 1);

    press(KEY_START, 1);
    chk_state("restart1", 0, 0, 0, 0, 0, 0);
    draw(5'b00100, 2'd1, 3'd5, 8'd5, 8'd0);
    draw(5'b00011, 2'd1, 3'd4, 8'd9, 8'd0);
    chk_state("target", 0, 9, 0, 0, 1, 1);
    press(KEY_DRAW, 1);
    chk_state("target_draw", 0, 9, 0, 0, 1, 1);

    press(KEY_START, 1);
    chk_state("restart2", 0, 0, 0, 0, 0, 0);
    draw(5'b00010, 2'd1, 3'd3, 8'd3, 8'd0);
    press(KEY_END1, 1);
    draw(5'b10010, 2'd3, 3'd3, 8'd3, 8'd3);
    press(KEY_END2, 1);
    chk_state("tie", 0, 3, 3, 1, 1, 3);

    // Reset while the draw sits in WAIT.
    press(KEY_START, 1);
    next_rnd = 5'b00100;
    @(posedge clk); #1;
    bus.key_valid = 1'b1;
    bus.keypad_in = KEY_DRAW;
    exp_rng++;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    chk_zero("midwait");

    chk("card_queue_left", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
